// File: rtl/tluh_pkg.sv
// TL-UH channel types and source-tag helpers shared by the host-to-device socket.
package tluh_pkg;

    localparam int TL_AW          = 32;
    localparam int TL_DW          = 32;
    localparam int TL_AIW         = 8;
    localparam int TL_DIW         = 1;
    localparam int TL_SZW         = 2;
    localparam int TL_DBW         = TL_DW / 8;
    localparam int TLUH_MAX_HOSTS = 8;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        Get            = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1
    } tl_d_op_e;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tluh_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tluh_d2h_t;

    function automatic int vbits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Host index occupies the top idxw bits of the source; the host keeps the rest.
    function automatic logic [TL_AIW-1:0] tluh_tag_src(input int idxw,
                                                       input logic [TL_AIW-1:0] idx,
                                                       input logic [TL_AIW-1:0] src);
        logic [TL_AIW-1:0] low_mask;
        low_mask = {TL_AIW{1'b1}} >> idxw;
        return (src & low_mask) | (idx << (TL_AIW - idxw));
    endfunction

    function automatic logic [TL_AIW-1:0] tluh_untag_src(input int idxw,
                                                         input logic [TL_AIW-1:0] src);
        return src & ({TL_AIW{1'b1}} >> idxw);
    endfunction

endpackage

// File: rtl/tluh_rr_arb.sv
// Round-robin arbiter with grant lock: a stalled winner keeps the grant until its beat fires.
module tluh_rr_arb
    import tluh_pkg::*;
#(
    parameter int NHOST = 3,
    parameter int IDXW  = vbits(NHOST)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NHOST-1:0] req_i,
    input  logic             fire_i,
    output logic [NHOST-1:0] gnt_o,
    output logic [IDXW-1:0]  gnt_idx_o,
    output logic             gnt_valid_o
);

    logic [IDXW-1:0] r_rr_ptr;
    logic            r_lock;
    logic [IDXW-1:0] r_gnt_q;
    logic [IDXW-1:0] w_rr_idx;
    logic            w_rr_found;
    int              w_pos;

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_pos      = 0;
        for (int k = 0; k < NHOST; k++) begin
            w_pos = int'(r_rr_ptr) + k;
            if (w_pos >= NHOST) w_pos = w_pos - NHOST;
            if (!w_rr_found && req_i[w_pos]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDXW'(w_pos);
            end
        end
    end

    always_comb begin
        gnt_idx_o = r_lock ? r_gnt_q : w_rr_idx;
        gnt_o     = '0;
        for (int i = 0; i < NHOST; i++) begin
            gnt_o[i] = (gnt_idx_o == IDXW'(i)) & (r_lock | w_rr_found);
        end
    end

    assign gnt_valid_o = |(gnt_o & req_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
            r_lock   <= 1'b0;
            r_gnt_q  <= '0;
        end else if (fire_i) begin
            r_rr_ptr <= (gnt_idx_o == IDXW'(NHOST - 1)) ? '0 : gnt_idx_o + 1'b1;
            r_lock   <= 1'b0;
        end else if (gnt_valid_o) begin
            r_lock   <= 1'b1;
            r_gnt_q  <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/tluh_socket_m1.sv
// N-host to 1-device TL-UH socket: arbitrated A channel, source-tagged D return, outstanding throttle.
module tluh_socket_m1
    import tluh_pkg::*;
#(
    parameter int NHOST      = 3,
    parameter int MAX_OUTSTD = 4,
    parameter int IDXW       = vbits(NHOST),
    parameter int HSRCW      = TL_AIW - IDXW
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  tluh_h2d_t tl_h_i [NHOST],
    output tluh_d2h_t tl_h_o [NHOST],
    output tluh_h2d_t tl_d_o,
    input  tluh_d2h_t tl_d_i
);

    localparam int OW = vbits(MAX_OUTSTD + 1);

    logic [OW-1:0]    r_outstd;
    logic [NHOST-1:0] w_req;
    logic [NHOST-1:0] w_gnt;
    logic [IDXW-1:0]  w_gnt_idx;
    logic             w_gnt_valid;
    logic             w_full;
    logic             w_a_fire;
    logic             w_d_fire;
    logic [IDXW-1:0]  w_d_idx;
    logic             w_d_ready_sel;
    tluh_h2d_t        w_gnt_req;

    always_comb begin
        for (int i = 0; i < NHOST; i++) w_req[i] = tl_h_i[i].a_valid;
    end

    tluh_rr_arb #(
        .NHOST (NHOST),
        .IDXW  (IDXW)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (w_req),
        .fire_i      (w_a_fire),
        .gnt_o       (w_gnt),
        .gnt_idx_o   (w_gnt_idx),
        .gnt_valid_o (w_gnt_valid)
    );

    assign w_full  = (r_outstd == OW'(MAX_OUTSTD));
    assign w_d_idx = tl_d_i.d_source[TL_AIW-1 -: IDXW];

    always_comb begin
        w_gnt_req     = tl_h_i[0];
        w_d_ready_sel = 1'b1;
        for (int i = 0; i < NHOST; i++) begin
            if (w_gnt[i]) w_gnt_req = tl_h_i[i];
            // Tags with no matching host are sunk with d_ready held high.
            if (w_d_idx == IDXW'(i)) w_d_ready_sel = tl_h_i[i].d_ready;
        end
    end

    always_comb begin
        tl_d_o          = w_gnt_req;
        tl_d_o.a_source = tluh_tag_src(IDXW, TL_AIW'(w_gnt_idx), w_gnt_req.a_source);
        tl_d_o.a_valid  = w_gnt_valid & ~w_full & ~rst_i;
        tl_d_o.d_ready  = w_d_ready_sel & ~rst_i;
    end

    always_comb begin
        for (int i = 0; i < NHOST; i++) begin
            tl_h_o[i]          = tl_d_i;
            tl_h_o[i].d_source = tluh_untag_src(IDXW, tl_d_i.d_source);
            tl_h_o[i].d_valid  = tl_d_i.d_valid & (w_d_idx == IDXW'(i)) & ~rst_i;
            tl_h_o[i].a_ready  = w_gnt[i] & tl_d_i.a_ready & ~w_full & ~rst_i;
        end
    end

    assign w_a_fire = tl_d_o.a_valid & tl_d_i.a_ready;
    assign w_d_fire = tl_d_i.d_valid & tl_d_o.d_ready;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstd <= '0;
        end else begin
            case ({w_a_fire, w_d_fire})
                2'b10:   r_outstd <= r_outstd + 1'b1;
                2'b01:   if (r_outstd != '0) r_outstd <= r_outstd - 1'b1;
                default: r_outstd <= r_outstd;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        w_d_fire |-> (r_outstd != '0));

    // The top IDXW source bits belong to the socket; hosts must leave them clear.
    for (genvar gi = 0; gi < NHOST; gi++) begin : g_src_chk
        a_src_tag_clear: assert property (@(posedge clk_i) disable iff (rst_i)
            tl_h_i[gi].a_valid |-> ((tl_h_i[gi].a_source >> HSRCW) == '0));
    end

endmodule
